writeback_regfile: RTL and testbench

WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

---
 rtl/regfile_pkg.sv | 14 +
 rtl/wb_mux.sv | 15 +
 rtl/writeback_regfile.sv | 83 ++++++++
 tb/tb_writeback_regfile.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and encodings for the write-back register file.
// Consumers: wb_mux, writeback_regfile.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int ZERO_REG   = 0;

    typedef enum logic {
        SEL_ALU = 1'b0,
        SEL_MEM = 1'b1
    } mem2reg_sel_e;

endpackage

// File: rtl/wb_mux.sv
// Write-back source select: load data or ALU result, purely combinational.
module wb_mux
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              i_sel,
    input  logic [DATA_W-1:0] i_alu,
    input  logic [DATA_W-1:0] i_mem,
    output logic [DATA_W-1:0] o_data
);

    assign o_data = (mem2reg_sel_e'(i_sel) == SEL_MEM) ? i_mem : i_alu;

endmodule

// File: rtl/writeback_regfile.sv
// Register file with MEM/WB write-back, two async read ports and a commit counter.
// Optional same-cycle write-through to the read ports when WB_BYPASS_EN is defined.
module writeback_regfile
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              CLOCK,
    input  logic              RESET_N,
    input  logic              RegWriteEN_In,
    input  logic              Mem2RegSEL_In,
    input  logic [DATA_W-1:0] ALUResult_In,
    input  logic [DATA_W-1:0] MemResult_In,
    input  logic [ADDR_W-1:0] WriteBackRegAddr_In,
    input  logic [ADDR_W-1:0] ReadAddrA_In,
    input  logic [ADDR_W-1:0] ReadAddrB_In,
    output logic [DATA_W-1:0] ReadDataA_Out,
    output logic [DATA_W-1:0] ReadDataB_Out,
    output logic [DATA_W-1:0] WriteBackData_Out,
    output logic [31:0]       RetireCount_Out
);

    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] w_wb_data;
    logic              w_commit;
    logic [DATA_W-1:0] w_rf [NREG];
    logic [31:0]       r_retire_count;

    wb_mux #(.DATA_W(DATA_W)) u_wb_mux (
        .i_sel  (Mem2RegSEL_In),
        .i_alu  (ALUResult_In),
        .i_mem  (MemResult_In),
        .o_data (w_wb_data)
    );

    assign WriteBackData_Out = w_wb_data;
    assign w_commit = RegWriteEN_In && (WriteBackRegAddr_In != ADDR_W'(ZERO_REG));

    // Register 0 is hardwired; only 1..NREG-1 get storage.
    assign w_rf[0] = '0;

    for (genvar g = 1; g < NREG; g++) begin : g_reg
        logic [DATA_W-1:0] r_q;

        always_ff @(posedge CLOCK or negedge RESET_N) begin
            if (!RESET_N) begin
                r_q <= '0;
            end else if (w_commit && (WriteBackRegAddr_In == ADDR_W'(g))) begin
                r_q <= w_wb_data;
            end
        end

        assign w_rf[g] = r_q;
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_retire_count <= '0;
        end else if (w_commit) begin
            r_retire_count <= r_retire_count + 32'd1;
        end
    end

    assign RetireCount_Out = r_retire_count;

`ifdef WB_BYPASS_EN
    logic w_byp_a;
    logic w_byp_b;

    // w_commit already excludes address 0; reset gating keeps reads at 0 in reset.
    assign w_byp_a = w_commit && RESET_N && (ReadAddrA_In == WriteBackRegAddr_In);
    assign w_byp_b = w_commit && RESET_N && (ReadAddrB_In == WriteBackRegAddr_In);

    assign ReadDataA_Out = w_byp_a ? w_wb_data : w_rf[ReadAddrA_In];
    assign ReadDataB_Out = w_byp_b ? w_wb_data : w_rf[ReadAddrB_In];
`else
    assign ReadDataA_Out = w_rf[ReadAddrA_In];
    assign ReadDataB_Out = w_rf[ReadAddrB_In];
`endif

endmodule

// File: tb/tb_writeback_regfile.sv
// Scoreboard bench for writeback_regfile; expectations come from a local register model.
module tb_writeback_regfile;

    localparam int DW = 32;
    localparam int AW = 5;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    logic          CLOCK = 1'b0;
    logic          RESET_N = 1'b0;
    logic          RegWriteEN_In = 1'b0;
    logic          Mem2RegSEL_In = 1'b0;
    logic [DW-1:0] ALUResult_In = '0;
    logic [DW-1:0] MemResult_In = '0;
    logic [AW-1:0] WriteBackRegAddr_In = '0;
    logic [AW-1:0] ReadAddrA_In = '0;
    logic [AW-1:0] ReadAddrB_In = '0;
    logic [DW-1:0] ReadDataA_Out;
    logic [DW-1:0] ReadDataB_Out;
    logic [DW-1:0] WriteBackData_Out;
    logic [31:0]   RetireCount_Out;

    writeback_regfile #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .CLOCK               (CLOCK),
        .RESET_N             (RESET_N),
        .RegWriteEN_In       (RegWriteEN_In),
        .Mem2RegSEL_In       (Mem2RegSEL_In),
        .ALUResult_In        (ALUResult_In),
        .MemResult_In        (MemResult_In),
        .WriteBackRegAddr_In (WriteBackRegAddr_In),
        .ReadAddrA_In        (ReadAddrA_In),
        .ReadAddrB_In        (ReadAddrB_In),
        .ReadDataA_Out       (ReadDataA_Out),
        .ReadDataB_Out       (ReadDataB_Out),
        .WriteBackData_Out   (WriteBackData_Out),
        .RetireCount_Out     (RetireCount_Out)
    );

    always #5 CLOCK = ~CLOCK;

    int          n_checks = 0;
    int          n_errors = 0;
    exp_t        sb_q[$];
    logic [31:0] model [32];
    logic [31:0] model_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic void push_exp(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endfunction

    task automatic pop_chk(input logic [31:0] obs);
        exp_t e;
        if (sb_q.size() == 0) begin
            chk("sb_underflow", obs, 32'hxxxx_xxxx);
        end else begin
            e = sb_q.pop_front();
            chk(e.tag, obs, e.val);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) model[i] = '0;
        model_cnt = '0;
    endfunction

    function automatic void model_commit(input logic en, input logic sel,
                                         input logic [31:0] alu, input logic [31:0] mem,
                                         input logic [4:0] addr);
        if (en && addr != 5'd0) begin
            model[addr] = sel ? mem : alu;
            model_cnt   = model_cnt + 32'd1;
        end
    endfunction

    // One write-back cycle: drive at negedge, check the mux output, commit at posedge.
    task automatic wb_cycle(input logic en, input logic sel, input logic [31:0] alu,
                            input logic [31:0] mem, input logic [4:0] addr);
        @(negedge CLOCK);
        RegWriteEN_In       = en;
        Mem2RegSEL_In       = sel;
        ALUResult_In        = alu;
        MemResult_In        = mem;
        WriteBackRegAddr_In = addr;
        #1;
        push_exp("wb_data", sel ? mem : alu);
        pop_chk(WriteBackData_Out);
        @(posedge CLOCK);
        model_commit(en, sel, alu, mem, addr);
        #1;
    endtask

    task automatic rd_chk(input logic [4:0] a, input logic [4:0] b, input logic do_cnt);
        @(negedge CLOCK);
        RegWriteEN_In = 1'b0;
        ReadAddrA_In  = a;
        ReadAddrB_In  = b;
        #1;
        push_exp($sformatf("rdA[%0d]", a), model[a]);
        push_exp($sformatf("rdB[%0d]", b), model[b]);
        pop_chk(ReadDataA_Out);
        pop_chk(ReadDataB_Out);
        if (do_cnt) begin
            push_exp("retire_cnt", model_cnt);
            pop_chk(RetireCount_Out);
        end
    endtask

    initial begin
        logic [31:0] byp_exp;
        model_reset();

        #12;
        RESET_N = 1'b1;
        for (int a = 0; a < 32; a++) rd_chk(5'(a), 5'(31 - a), (a == 0 || a == 31));

        wb_cycle(1'b1, 1'b0, 32'h0000_1234, 32'h0, 5'd5);
        rd_chk(5'd5, 5'd5, 1'b1);

        wb_cycle(1'b1, 1'b1, 32'h0, 32'hDEAD_BEEF, 5'd0);
        rd_chk(5'd0, 5'd5, 1'b1);

        wb_cycle(1'b0, 1'b1, 32'h0, 32'hCAFE_F00D, 5'd5);
        rd_chk(5'd5, 5'd0, 1'b1);

        wb_cycle(1'b1, 1'b0, 32'h0000_0011, 32'h0, 5'd7);
        @(negedge CLOCK);
        RegWriteEN_In       = 1'b1;
        Mem2RegSEL_In       = 1'b0;
        ALUResult_In        = 32'h0000_0022;
        WriteBackRegAddr_In = 5'd7;
        ReadAddrA_In        = 5'd7;
        ReadAddrB_In        = 5'd7;
        #1;
`ifdef WB_BYPASS_EN
        byp_exp = 32'h0000_0022;
`else
        byp_exp = 32'h0000_0011;
`endif
        push_exp("bypA_pre", byp_exp);
        push_exp("bypB_pre", byp_exp);
        pop_chk(ReadDataA_Out);
        pop_chk(ReadDataB_Out);
        @(posedge CLOCK);
        model_commit(1'b1, 1'b0, 32'h22, 32'h0, 5'd7);
        #1;
        push_exp("bypA_post", model[7]);
        push_exp("bypB_post", model[7]);
        pop_chk(ReadDataA_Out);
        pop_chk(ReadDataB_Out);

        wb_cycle(1'b1, 1'b0, 32'h0000_0033, 32'h0, 5'd9);
        wb_cycle(1'b1, 1'b1, 32'h0, 32'h0000_0044, 5'd9);
        rd_chk(5'd9, 5'd7, 1'b1);

        for (int i = 0; i < 20; i++)
            wb_cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                     $urandom, $urandom, 5'($urandom_range(0, 31)));
        for (int a = 0; a < 32; a += 3) rd_chk(5'(a), 5'(a ^ 1), (a == 30));

        wb_cycle(1'b1, 1'b0, 32'h0000_00AA, 32'h0, 5'd3);
        @(negedge CLOCK);
        RegWriteEN_In       = 1'b1;
        Mem2RegSEL_In       = 1'b0;
        ALUResult_In        = 32'h0000_0055;
        WriteBackRegAddr_In = 5'd4;
        ReadAddrA_In        = 5'd3;
        ReadAddrB_In        = 5'd4;
        #2;
        RESET_N = 1'b0;
        model_reset();
        #1;
        push_exp("rst_rd3", 32'h0);
        push_exp("rst_rd4", 32'h0);
        push_exp("rst_cnt", 32'h0);
        pop_chk(ReadDataA_Out);
        pop_chk(ReadDataB_Out);
        pop_chk(RetireCount_Out);
        @(posedge CLOCK);
        #1;
        push_exp("rst_commit_drop", 32'h0);
        push_exp("rst_commit_cnt", 32'h0);
        pop_chk(ReadDataB_Out);
        pop_chk(RetireCount_Out);
        @(negedge CLOCK);
        RESET_N = 1'b1;
        @(posedge CLOCK);
        model_commit(1'b1, 1'b0, 32'h55, 32'h0, 5'd4);
        #1;
        rd_chk(5'd4, 5'd3, 1'b1);

        @(negedge CLOCK);
        RegWriteEN_In = 1'b0;
        force dut.r_retire_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_retire_count;
        model_cnt = 32'hFFFF_FFFF;
        push_exp("cnt_forced", model_cnt);
        pop_chk(RetireCount_Out);
        wb_cycle(1'b1, 1'b1, 32'h0, 32'h0000_0777, 5'd12);
        rd_chk(5'd12, 5'd4, 1'b1);

        if (sb_q.size() != 0) chk("sb_leftover", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: sim did not finish");
        $fatal(1);
    end

endmodule
